fp_div_seq: RTL

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq_if.sv | 21 ++
 rtl/fp_div_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for the sequential FP32 divider.
// The master side presents operands and consumes quotients; the slave side is the divider.
interface fp_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q
    );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential FP32 divider: restoring mantissa division (one quotient bit per cycle),
// round-to-nearest-even, overflow to infinity, underflow flushed to zero.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst,
    fp_div_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [25:0] rem_q, rem_d;
    logic [23:0] div_q, div_d;
    logic [25:0] quo_q, quo_d;
    logic        sign_q, sign_d;
    logic [7:0]  aExp_q, aExp_d;
    logic [7:0]  bExp_q, bExp_d;
    logic [31:0] q_q, q_d;

    logic        aZero, aInf, aNan, bZero, bInf, bNan, isSpecial, inSign;
    logic [31:0] specialRes;

    logic signed [9:0] expNorm, expFinal;
    logic [22:0] frac;
    logic        guard, sticky;
    logic [23:0] fracInc;
    logic [31:0] roundRes;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.q         = q_q;

    // Special-case result is resolved straight from the incoming operands.
    always_comb begin
        aZero  = (bus.a[30:0] == 31'd0);
        bZero  = (bus.b[30:0] == 31'd0);
        aNan   = ((bus.a[30:23] == 8'hFF) && (bus.a[22:0] != 23'd0)) || (bus.a == 32'hFFFF_FFFF);
        bNan   = ((bus.b[30:23] == 8'hFF) && (bus.b[22:0] != 23'd0)) || (bus.b == 32'hFFFF_FFFF);
        aInf   = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == 23'd0);
        bInf   = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] == 23'd0);
        inSign = bus.a[31] ^ bus.b[31];
        isSpecial  = aZero | bZero | aNan | bNan | aInf | bInf;
        specialRes = {inSign, 31'd0};
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
            specialRes = 32'hFFFF_FFFF;
        end else if (bZero || aInf) begin
            specialRes = {inSign, 8'hFF, 23'd0};
        end
    end

    always_comb begin
        expNorm = {2'b00, aExp_q} - {2'b00, bExp_q} + 10'd126 + {9'd0, quo_q[25]};
        if (quo_q[25]) begin
            frac   = quo_q[24:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != 26'd0);
        end else begin
            frac   = quo_q[23:1];
            guard  = quo_q[0];
            sticky = (rem_q != 26'd0);
        end
        fracInc  = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
        expFinal = expNorm + {9'd0, fracInc[23]};
        if (expFinal >= 10'sd255) begin
            roundRes = {sign_q, 8'hFF, 23'd0};
        end else if (expFinal <= 10'sd0) begin
            roundRes = {sign_q, 31'd0};
        end else begin
            roundRes = {sign_q, expFinal[7:0], fracInc[22:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        sign_d  = sign_q;
        aExp_d  = aExp_q;
        bExp_d  = bExp_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = inSign;
                    aExp_d = bus.a[30:23];
                    bExp_d = bus.b[30:23];
                    cnt_d  = 5'd0;
                    quo_d  = 26'd0;
                    rem_d  = {2'b01, bus.a[22:0]};
                    div_d  = {1'b1, bus.b[22:0]};
                    if (isSpecial) begin
                        q_d     = specialRes;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (rem_q >= {2'b00, div_q}) begin
                    quo_d = {quo_q[24:0], 1'b1};
                    rem_d = (rem_q - {2'b00, div_q}) << 1;
                end else begin
                    quo_d = {quo_q[24:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                q_d     = roundRes;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 26'd0;
            div_q   <= 24'd0;
            quo_q   <= 26'd0;
            sign_q  <= 1'b0;
            aExp_q  <= 8'd0;
            bExp_q  <= 8'd0;
            q_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            sign_q  <= sign_d;
            aExp_q  <= aExp_d;
            bExp_q  <= bExp_d;
            q_q     <= q_d;
        end
    end

endmodule
